// File: rtl/stbus_rx_deframer.sv
// stbus_rx_deframer
//   ST-BUS receive deframer. Tracks the 512-cycle frame position from the f0
//   frame pulse, qualifies frame alignment with a HUNT/CHECK/LOCK machine,
//   extracts one TDM channel (CH_SEL) byte per frame and queues it in a small
//   byte FIFO for a CPU reader.
//
// Parameters
//   CH_SEL      TDM channel (0..31) to extract
//   FIFO_DEPTH  byte FIFO depth, power of two, 2..16
//
// Ports
//   c4            4.096 MHz ST-BUS clock, rising edge
//   reset_in_rg   asynchronous active-high reset
//   f0            active-low frame pulse
//   data_from_dt  serial TDM data, MSB first, two c4 cycles per bit
//   rd_en         pop request (ignored while empty)
//   ovf_clr       clear sticky overflow flag
//   rd_data       FIFO head byte (0 while empty)
//   rd_valid      FIFO non-empty
//   locked        frame alignment is locked
//   frame_err     one-cycle pulse on a framing violation
//   ovf           sticky, set when a byte is dropped on a full FIFO
//   cpu_int       registered (rd_valid | ovf)
//   drop_cnt      saturating dropped-byte count (only with STBUS_RX_DROPCNT_EN)
//
// Build option
//   STBUS_RX_DROPCNT_EN  adds the drop_cnt output and its counter.

module stbus_rx_deframer #(
  parameter int unsigned CH_SEL     = 0,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       c4,
  input  logic       reset_in_rg,
  input  logic       f0,
  input  logic       data_from_dt,
  input  logic       rd_en,
  input  logic       ovf_clr,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       locked,
  output logic       frame_err,
  output logic       ovf,
  output logic       cpu_int
`ifdef STBUS_RX_DROPCNT_EN
  ,
  output logic [7:0] drop_cnt
`endif
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [4:0]  ChSel = 5'(CH_SEL);

  localparam logic [1:0] StHunt  = 2'd0;
  localparam logic [1:0] StCheck = 2'd1;
  localparam logic [1:0] StLock  = 2'd2;

  logic [8:0]    cnt_q, cnt_d;
  logic [7:0]    sr_q, sr_d;
  logic [1:0]    state_q, state_d;
  logic          frame_err_q, frame_err_d;
  logic          ovf_q, ovf_d;
  logic          cpu_int_q, cpu_int_d;
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [7:0]    mem_d [FIFO_DEPTH];

  logic          f0_low;
  logic          cnt_end;
  logic          phase;
  logic [7:0]    new_byte;
  logic          wr_req;
  logic          empty;
  logic          full;
  logic          pop;
  logic          push;
  logic          drop;
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] rd_idx;

  assign f0_low  = ~f0;
  assign cnt_end = (cnt_q == 9'd511);
  assign phase   = cnt_q[0];

  // Byte completed at this edge includes the bit being sampled now.
  assign new_byte = {sr_q[6:0], data_from_dt};

  // The shift register always holds the last eight sampled bits, and a write
  // happens only at bit 7 of the selected channel while already locked. Any
  // cnt reset or state change restarts the channel from bit 0, so a cut-off
  // partial byte can never reach the FIFO.
  assign wr_req = (state_q == StLock) && (cnt_q[8:4] == ChSel) &&
                  (cnt_q[3:1] == 3'd7) && phase;

  assign wr_idx = wr_ptr_q[AW-1:0];
  assign rd_idx = rd_ptr_q[AW-1:0];
  assign empty  = (wr_ptr_q == rd_ptr_q);
  assign full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_idx == rd_idx);
  assign pop    = rd_en & ~empty;
  // When full, a simultaneous pop frees the head slot that the write reuses.
  assign push   = wr_req & (~full | pop);
  assign drop   = wr_req & full & ~pop;

  // Frame position counter.
  always_comb begin
    cnt_d = f0_low ? 9'd0 : cnt_q + 9'd1;
  end

  always_comb begin
    sr_d = sr_q;
    if (phase) begin
      sr_d = new_byte;
    end
  end

  // Alignment state machine.
  always_comb begin
    state_d     = state_q;
    frame_err_d = 1'b0;
    case (state_q)
      StHunt: begin
        if (f0_low) begin
          state_d = StCheck;
        end
      end
      StCheck: begin
        if (f0_low) begin
          if (cnt_end) begin
            state_d = StLock;
          end else begin
            frame_err_d = 1'b1;
          end
        end else if (cnt_end) begin
          state_d = StHunt;
        end
      end
      StLock: begin
        if (f0_low) begin
          if (!cnt_end) begin
            state_d     = StCheck;
            frame_err_d = 1'b1;
          end
        end else if (cnt_end) begin
          state_d     = StHunt;
          frame_err_d = 1'b1;
        end
      end
      default: state_d = StHunt;
    endcase
  end

  // FIFO next state.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_idx] = new_byte;
      wr_ptr_d      = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  // A coincident drop wins over ovf_clr.
  always_comb begin
    ovf_d     = drop | (ovf_q & ~ovf_clr);
    cpu_int_d = rd_valid | ovf_q;
  end

  always_ff @(posedge c4 or posedge reset_in_rg) begin
    if (reset_in_rg) begin
      cnt_q       <= 9'd0;
      sr_q        <= 8'd0;
      state_q     <= StHunt;
      frame_err_q <= 1'b0;
      ovf_q       <= 1'b0;
      cpu_int_q   <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= 8'd0;
      end
    end else begin
      cnt_q       <= cnt_d;
      sr_q        <= sr_d;
      state_q     <= state_d;
      frame_err_q <= frame_err_d;
      ovf_q       <= ovf_d;
      cpu_int_q   <= cpu_int_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      mem_q       <= mem_d;
    end
  end

`ifdef STBUS_RX_DROPCNT_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (ovf_clr) begin
      drop_cnt_d = drop ? 8'd1 : 8'd0;
    end else if (drop && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge c4 or posedge reset_in_rg) begin
    if (reset_in_rg) begin
      drop_cnt_q <= 8'd0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_cnt = drop_cnt_q;
`endif

  assign rd_valid  = ~empty;
  assign rd_data   = empty ? 8'd0 : mem_q[rd_idx];
  assign locked    = (state_q == StLock);
  assign frame_err = frame_err_q;
  assign ovf       = ovf_q;
  assign cpu_int   = cpu_int_q;

endmodule

// File: tb/tb_stbus_rx_deframer.sv
// Directed bench for stbus_rx_deframer. dut0 extracts channel 0, dut1 extracts
// channel 31; both share the frame pulse and serial data. The bench tracks the
// frame position itself and builds the serial stream from per-channel bytes.

module tb_stbus_rx_deframer;

  logic       c4;
  logic       reset_in_rg;
  logic       f0;
  logic       data_from_dt;
  logic       rd_en0, ovf_clr0, rd_en1, ovf_clr1;
  logic [7:0] rd_data0, rd_data1;
  logic       rd_valid0, rd_valid1, locked0, locked1;
  logic       frame_err0, frame_err1, ovf0, ovf1, cpu_int0, cpu_int1;
`ifdef STBUS_RX_DROPCNT_EN
  logic [7:0] drop_cnt0, drop_cnt1;
`endif

  int         tests;
  int         fails;
  int         err0;
  logic [8:0] pos;
  logic [7:0] ch0_byte;

  stbus_rx_deframer #(.CH_SEL(0), .FIFO_DEPTH(4)) dut0 (
    .c4           (c4),
    .reset_in_rg  (reset_in_rg),
    .f0           (f0),
    .data_from_dt (data_from_dt),
    .rd_en        (rd_en0),
    .ovf_clr      (ovf_clr0),
    .rd_data      (rd_data0),
    .rd_valid     (rd_valid0),
    .locked       (locked0),
    .frame_err    (frame_err0),
    .ovf          (ovf0),
    .cpu_int      (cpu_int0)
`ifdef STBUS_RX_DROPCNT_EN
    ,
    .drop_cnt     (drop_cnt0)
`endif
  );

  stbus_rx_deframer #(.CH_SEL(31), .FIFO_DEPTH(4)) dut1 (
    .c4           (c4),
    .reset_in_rg  (reset_in_rg),
    .f0           (f0),
    .data_from_dt (data_from_dt),
    .rd_en        (rd_en1),
    .ovf_clr      (ovf_clr1),
    .rd_data      (rd_data1),
    .rd_valid     (rd_valid1),
    .locked       (locked1),
    .frame_err    (frame_err1),
    .ovf          (ovf1),
    .cpu_int      (cpu_int1)
`ifdef STBUS_RX_DROPCNT_EN
    ,
    .drop_cnt     (drop_cnt1)
`endif
  );

  initial c4 = 1'b0;
  always #5 c4 = ~c4;

  always @(negedge c4) begin
    if (frame_err0 === 1'b1) err0++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic data_bit(input logic [8:0] p);
    logic [7:0] b;
    logic [4:0] ch;
    logic [2:0] idx;
    ch  = p[8:4];
    idx = p[3:1];
    if (ch == 5'd0) b = ch0_byte;
    else if (ch == 5'd31) b = 8'h3C;
    else b = 8'hC3 ^ {3'b000, ch};
    return b[3'd7 - idx];
  endfunction

  // One c4 cycle: present inputs for the edge at frame position pos.
  task automatic tick(input logic f0_low);
    f0           = ~f0_low;
    data_from_dt = data_bit(pos);
    @(posedge c4);
    #1;
    pos = f0_low ? 9'd0 : pos + 9'd1;
    f0  = 1'b1;
  endtask

  // framed: drive f0 low whenever the position reaches 511.
  task automatic run_ticks(input int n, input logic framed);
    for (int i = 0; i < n; i++) begin
      tick(framed && (pos == 9'd511));
    end
  endtask

  task automatic pop0();
    rd_en0 = 1'b1;
    tick(1'b0);
    rd_en0 = 1'b0;
  endtask

  initial begin
    tests        = 0;
    fails        = 0;
    err0         = 0;
    pos          = 9'd0;
    ch0_byte     = 8'hA5;
    f0           = 1'b1;
    data_from_dt = 1'b0;
    rd_en0       = 1'b0;
    ovf_clr0     = 1'b0;
    rd_en1       = 1'b0;
    ovf_clr1     = 1'b0;
    reset_in_rg  = 1'b1;
    #1;
    check("rst_rd_valid", rd_valid0, 1'b0);
    check("rst_rd_data", rd_data0, 8'h00);
    check("rst_locked", locked0, 1'b0);
    check("rst_frame_err", frame_err0, 1'b0);
    check("rst_ovf", ovf0, 1'b0);
    check("rst_cpu_int", cpu_int0, 1'b0);
    @(posedge c4);
    @(posedge c4);
    #1;
    reset_in_rg = 1'b0;

    // Two correctly spaced frame pulses lock the receiver.
    run_ticks(512, 1'b1);
    check("lock_after_f0_1", locked0, 1'b0);
    run_ticks(512, 1'b1);
    check("lock_after_f0_2", locked0, 1'b1);
    check("lock_after_f0_2_ch31", locked1, 1'b1);
    check("no_write_before_lock", rd_valid0, 1'b0);

    // Third frame: channel 0 byte lands at position 15.
    run_ticks(16, 1'b1);
    check("ch0_valid", rd_valid0, 1'b1);
    check("ch0_data", rd_data0, 8'hA5);
    check("ch0_cpu_int_lag", cpu_int0, 1'b0);
    tick(1'b0);
    check("ch0_cpu_int", cpu_int0, 1'b1);
    pop0();
    check("ch0_popped", rd_valid0, 1'b0);

    // Channel 31 byte completes on the cnt==511 edge.
    run_ticks(493, 1'b1);
    check("ch31_before_end", rd_valid1, 1'b0);
    tick(1'b1);
    check("ch31_valid", rd_valid1, 1'b1);
    check("ch31_data", rd_data1, 8'h3C);
    check("ch31_cpu_int_lag", cpu_int1, 1'b0);
    tick(1'b0);
    check("ch31_cpu_int", cpu_int1, 1'b1);

    // Fourth frame still delivers 0xA5; no framing errors so far.
    run_ticks(15, 1'b1);
    check("ch0_frame4_data", rd_data0, 8'hA5);
    check("no_frame_err_locked", err0, 0);
    pop0();

    // Early f0 at position 300 while locked.
    run_ticks(283, 1'b1);
    tick(1'b1);
    check("early_f0_err", frame_err0, 1'b1);
    check("early_f0_unlocked", locked0, 1'b0);
    tick(1'b0);
    check("early_f0_err_pulse", frame_err0, 1'b0);
    run_ticks(510, 1'b0);
    tick(1'b1);
    check("early_f0_relock", locked0, 1'b1);
    check("early_f0_no_write", rd_valid0, 1'b0);
    check("early_f0_err_count", err0, 1);

    // Missing f0 for one frame while locked.
    run_ticks(16, 1'b1);
    check("pre_miss_data", rd_data0, 8'hA5);
    pop0();
    run_ticks(494, 1'b1);
    tick(1'b0);
    check("miss_f0_err", frame_err0, 1'b1);
    check("miss_f0_hunt", locked0, 1'b0);
    tick(1'b0);
    run_ticks(510, 1'b0);
    tick(1'b1);
    check("miss_hunt_no_write", rd_valid0, 1'b0);
    check("miss_check_unlocked", locked0, 1'b0);
    run_ticks(511, 1'b0);
    tick(1'b1);
    check("miss_relock", locked0, 1'b1);
    check("miss_check_no_write", rd_valid0, 1'b0);
    check("miss_err_count", err0, 2);

    // Five frames without reads: four bytes kept, fifth dropped.
    for (int f = 0; f < 5; f++) begin
      ch0_byte = 8'(8'h11 * (f + 1));
      run_ticks(512, 1'b1);
    end
    check("ovf_set", ovf0, 1'b1);
    check("ovf_head", rd_data0, 8'h11);
    check("ovf_cpu_int", cpu_int0, 1'b1);
`ifdef STBUS_RX_DROPCNT_EN
    check("drop_cnt_1", drop_cnt0, 8'd1);
`endif
    ch0_byte = 8'h66;
    ovf_clr0 = 1'b1;
    tick(1'b0);
    ovf_clr0 = 1'b0;
    check("ovf_cleared", ovf0, 1'b0);
    check("ovf_clr_keeps_data", rd_valid0, 1'b1);
`ifdef STBUS_RX_DROPCNT_EN
    check("drop_cnt_cleared", drop_cnt0, 8'd0);
`endif

    // Write and pop together while full.
    run_ticks(14, 1'b1);
    rd_en0 = 1'b1;
    tick(1'b0);
    rd_en0 = 1'b0;
    check("full_wr_pop_no_ovf", ovf0, 1'b0);
    check("full_wr_pop_head", rd_data0, 8'h22);
    pop0();
    check("drain_33", rd_data0, 8'h33);
    pop0();
    check("drain_44", rd_data0, 8'h44);
    pop0();
    check("drain_66", rd_data0, 8'h66);
    pop0();
    check("drain_empty", rd_valid0, 1'b0);
    check("drain_empty_data", rd_data0, 8'h00);

    // Reset mid-byte with two bytes queued.
    ch0_byte = 8'h77;
    run_ticks(492, 1'b1);
    run_ticks(512, 1'b1);
    run_ticks(512, 1'b1);
    run_ticks(6, 1'b1);
    check("pre_reset_queued", rd_valid0, 1'b1);
    reset_in_rg = 1'b1;
    #1;
    check("mid_rst_rd_valid", rd_valid0, 1'b0);
    check("mid_rst_rd_data", rd_data0, 8'h00);
    check("mid_rst_locked", locked0, 1'b0);
    check("mid_rst_cpu_int", cpu_int0, 1'b0);
    check("mid_rst_ovf", ovf0, 1'b0);
    check("mid_rst_frame_err", frame_err0, 1'b0);
    @(posedge c4);
    @(posedge c4);
    #1;
    reset_in_rg = 1'b0;
    pos         = 9'd0;
    run_ticks(512, 1'b1);
    check("post_rst_f0_1_unlocked", locked0, 1'b0);
    check("post_rst_f0_1_empty", rd_valid0, 1'b0);
    run_ticks(512, 1'b1);
    check("post_rst_relock", locked0, 1'b1);
    check("post_rst_still_empty", rd_valid0, 1'b0);
    run_ticks(16, 1'b1);
    check("post_rst_data", rd_data0, 8'h77);
    check("final_err_count", err0, 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/stbus_rx_deframer.md
STBUS_RX_DEFRAMER -- requirements
Module: stbus_rx_deframer

Interface
REQ-001 SHALL have parameter CH_SEL, default 0, TDM channel (0..31) extracted from the frame.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, byte FIFO depth (power of two, 2..16).
REQ-003 SHALL have port c4 input 1: the only clock, rising edge, 4.096 MHz ST-BUS clock.
REQ-004 SHALL have port reset_in_rg input 1: asynchronous, active-high reset.
REQ-005 SHALL have port f0 input 1: active-low frame pulse, sampled on rising c4.
REQ-006 SHALL have port data_from_dt input 1: serial TDM data, MSB first, 2 c4 cycles per bit.
REQ-007 SHALL have port rd_en input 1: pop request.
REQ-008 SHALL have port ovf_clr input 1: clears the sticky overflow flag.
REQ-009 SHALL have port rd_data output 8: FIFO head byte.
REQ-010 SHALL have port rd_valid output 1: FIFO non-empty.
REQ-011 SHALL have port locked output 1: high while the state is LOCK.
REQ-012 SHALL have port frame_err output 1: one-cycle pulse on a framing violation.
REQ-013 SHALL have port ovf output 1: sticky, set when a byte is dropped.
REQ-014 SHALL have port cpu_int output 1: registered, equal to (rd_valid | ovf) of the previous cycle.

Function
REQ-015 SHALL keep a 9-bit cnt: set to 0 on every edge with f0==0, otherwise increment, wrapping 511->0.
REQ-016 SHALL decode cnt as channel=cnt[8:4], bit=cnt[3:1] and phase=cnt[0].
REQ-017 SHALL shift data_from_dt into an 8-bit shift register on edges with phase==1, MSB first.
REQ-018 SHALL write the completed byte (including the bit sampled at that edge) into the FIFO at the edge with channel==CH_SEL, bit==7, phase==1 and state==LOCK.
REQ-019 SHALL run an FSM with states HUNT, CHECK and LOCK.
REQ-020 SHALL move HUNT->CHECK on any f0 low, with no frame_err.
REQ-021 SHALL, in CHECK: move to LOCK on f0 low at cnt==511; stay in CHECK and pulse frame_err on f0 low at any other cnt; move to HUNT with no f0 low at cnt==511.
REQ-022 SHALL, in LOCK: stay on f0 low at cnt==511; move to CHECK and pulse frame_err on f0 low at any other cnt; move to HUNT and pulse frame_err with no f0 low at cnt==511.
REQ-023 SHALL discard a partially received selected-channel byte when it is cut off by a state change or by a cnt reset.
REQ-024 SHALL present the head byte combinationally on rd_data, and pop on rd_en & rd_valid; rd_en while empty SHALL be ignored.
REQ-025 SHALL accept a write and a pop in the same cycle at any fill level, including full; the count is unchanged.
REQ-026 SHALL drop the byte and set ovf on a write while full with no pop; FIFO contents are unchanged.
REQ-027 SHALL clear ovf on ovf_clr; when ovf_clr and a new overflow coincide, ovf SHALL remain set.
REQ-028 SHALL make the first written byte visible on rd_valid/rd_data in the cycle after the write edge; cpu_int follows one cycle later.

Reset
REQ-029 SHALL, on reset_in_rg high, immediately set: state HUNT, cnt 0, shift register 0, FIFO empty, rd_valid 0, rd_data 0, locked 0, frame_err 0, ovf 0, cpu_int 0.
REQ-030 SHALL lose the FIFO contents and any in-progress byte when reset is asserted mid-frame; after release, lock requires two f0 pulses 512 cycles apart again.

Configuration
REQ-031 SHALL, with STBUS_RX_DROPCNT_EN defined, add output drop_cnt 8: a saturating count of dropped bytes, reset to 0, cleared by ovf_clr (a drop in the same cycle as ovf_clr yields 1).
REQ-032 SHALL, without STBUS_RX_DROPCNT_EN, have no drop_cnt port and no counter logic; all other behaviour is identical.

Verification
REQ-033 Bench SHALL cover: f0 pulses every 512 cycles with CH_SEL=0, channel 0 = 0xA5 -> locked high after the 2nd f0, 0xA5 read from the 3rd frame onward, frame_err never pulses.
REQ-034 Bench SHALL cover: CH_SEL=31, channel 31 = 0x3C -> byte written at the cnt==511 edge, rd_valid high next cycle, cpu_int high the cycle after.
REQ-035 Bench SHALL cover: in LOCK, f0 arrives at cnt==300 -> frame_err for 1 cycle, locked low, relock on the next correctly spaced f0 at cnt==511.
REQ-036 Bench SHALL cover: in LOCK, f0 omitted for one frame -> frame_err at cnt==511, state HUNT, no bytes written until relocked.
REQ-037 Bench SHALL cover: FIFO_DEPTH=4, no reads for 5 frames -> 4 bytes held, ovf=1, drop_cnt=1 (macro on); ovf_clr pulse -> ovf=0, drop_cnt=0.
REQ-038 Bench SHALL cover: reset_in_rg asserted mid-byte with 2 bytes queued -> all outputs 0 at once, and after release rd_valid stays 0 until relock.
